// File: rtl/vote_collector.sv
// vote_collector: opens a timed voting window, latches yes/no votes from four voters and
// presents the yes mask with a valid/ack handshake. Optional macro: VOTE_REVOTE_EN (allow recasting).
module vote_collector #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_yes,
  input  logic [3:0] vote_no,
  input  logic       ballot_ack,
  output logic [3:0] ballot,
  output logic       ballot_valid,
  output logic [3:0] voted,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OPEN, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WINDOW_CYCLES - 1);

  state_t           state, state_next;
  logic [3:0]       ballot_next, voted_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic             close_window;

  // State, ballot, voted mask and window counter all update together on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ballot  <= 4'b0000;
      voted   <= 4'b0000;
      counter <= '0;
    end else begin
      state   <= state_next;
      ballot  <= ballot_next;
      voted   <= voted_next;
      counter <= counter_next;
    end
  end

  // Close decision looks at the voted mask including this edge's votes, so the fourth vote closes at once
  always_comb begin
    state_next   = state;
    ballot_next  = ballot;
    voted_next   = voted;
    counter_next = counter;
    close_window = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next   = OPEN;
          ballot_next  = 4'b0000;
          voted_next   = 4'b0000;
          counter_next = '0;
        end
      end

      OPEN: begin
        for (int i = 0; i < 4; i++) begin
`ifdef VOTE_REVOTE_EN
          if (vote_yes[i] ^ vote_no[i]) begin
`else
          if ((vote_yes[i] ^ vote_no[i]) && !voted[i]) begin
`endif
            voted_next[i]  = 1'b1;
            ballot_next[i] = vote_yes[i];
          end
        end

`ifdef VOTE_REVOTE_EN
        close_window = (counter == LAST_COUNT);
`else
        close_window = (voted_next == 4'b1111) || (counter == LAST_COUNT);
`endif

        if (close_window) begin
          state_next = HOLD;
        end else begin
          counter_next = counter + CNT_W'(1);
        end
      end

      HOLD: begin
        if (ballot_ack) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ballot_valid = (state == HOLD);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed scenarios plus randomized windows
// checked against a per-voter reference model of the voting rules.
module tb_vote_collector;

  localparam int W = 8;
`ifdef VOTE_REVOTE_EN
  localparam bit REVOTE = 1'b1;
`else
  localparam bit REVOTE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_yes;
  logic [3:0] vote_no;
  logic       ballot_ack;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic [3:0] voted;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Strobes applied on the n-th edge after the start edge
  logic [3:0] seq_yes [1:W+3];
  logic [3:0] seq_no  [1:W+3];

  int         obs_close;
  logic [3:0] obs_ballot, obs_voted;
  int         exp_close;
  logic [3:0] exp_ballot, exp_voted;

  vote_collector #(.WINDOW_CYCLES(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .ballot_ack(ballot_ack), .ballot(ballot), .ballot_valid(ballot_valid),
    .voted(voted), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_seq();
    for (int j = 1; j <= W + 3; j++) begin
      seq_yes[j] = 4'b0000;
      seq_no[j]  = 4'b0000;
    end
  endtask

  // Reference model: walk the window edge by edge applying the voting rules to each voter
  task automatic predict();
    logic [3:0] cast;
    logic [3:0] yes_mask;
    cast      = 4'b0000;
    yes_mask  = 4'b0000;
    exp_close = W;
    for (int j = 1; j <= W; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (seq_yes[j][i] != seq_no[j][i] && (REVOTE || !cast[i])) begin
          cast[i]     = 1'b1;
          yes_mask[i] = seq_yes[j][i];
        end
      end
      if (!REVOTE && cast == 4'b1111) begin
        exp_close = j;
        break;
      end
    end
    exp_ballot = yes_mask;
    exp_voted  = cast;
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT in HOLD
  task automatic run_window();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    obs_close = -1;
    for (int j = 1; j <= W + 3; j++) begin
      vote_yes = seq_yes[j];
      vote_no  = seq_no[j];
      @(posedge clk);
      @(negedge clk);
      vote_yes = 4'b0000;
      vote_no  = 4'b0000;
      if (ballot_valid && obs_close < 0) obs_close = j;
    end
    obs_ballot = ballot;
    obs_voted  = voted;
  endtask

  task automatic ack_edge();
    ballot_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ballot_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ballot !== 4'b0000 || voted !== 4'b0000 || busy !== 1'b0 || ballot_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: actual b=%b v=%b busy=%b valid=%b required 0000/0000/0/0",
               ballot, voted, busy, ballot_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    vote_yes = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    vote_yes = 4'b0000;
    checks++;
    if (voted !== 4'b0001 || ballot !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_prevote: actual b=%b v=%b busy=%b required 0001/0001/1",
               ballot, voted, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ballot !== 4'b0000 || voted !== 4'b0000 || busy !== 1'b0 || ballot_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: actual b=%b v=%b busy=%b valid=%b required 0000/0000/0/0",
               ballot, voted, busy, ballot_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: actual busy=%b required 0", busy);
    end
  endtask

  task automatic test_early_close();
    clear_seq();
    seq_yes[1] = 4'b0001;
    seq_yes[2] = 4'b0010;
    seq_yes[3] = 4'b0100;
    seq_no[4]  = 4'b1000;
    predict();
    run_window();
    checks++;
    if (obs_close !== exp_close) begin
      failures++;
      $display("[TB] FAIL early_close_edge: actual=%0d required=%0d", obs_close, exp_close);
    end
    checks++;
    if (obs_ballot !== exp_ballot || obs_voted !== exp_voted) begin
      failures++;
      $display("[TB] FAIL early_close_ballot: actual b=%b v=%b required b=%b v=%b",
               obs_ballot, obs_voted, exp_ballot, exp_voted);
    end
    ack_edge();
    checks++;
    if (ballot_valid !== 1'b0 || busy !== 1'b0 || ballot !== exp_ballot) begin
      failures++;
      $display("[TB] FAIL early_close_ack: actual valid=%b busy=%b b=%b required 0/0/%b",
               ballot_valid, busy, ballot, exp_ballot);
    end
  endtask

  task automatic test_timeout();
    clear_seq();
    seq_yes[3] = 4'b0100;
    predict();
    run_window();
    checks++;
    if (obs_close !== W) begin
      failures++;
      $display("[TB] FAIL timeout_edge: actual=%0d required=%0d", obs_close, W);
    end
    checks++;
    if (obs_ballot !== 4'b0100 || obs_voted !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL timeout_ballot: actual b=%b v=%b required b=0100 v=0100",
               obs_ballot, obs_voted);
    end
    ack_edge();
  endtask

  task automatic test_boundary();
    clear_seq();
    seq_yes[3]     = 4'b0100;
    seq_yes[W]     = 4'b0010;
    seq_yes[W + 1] = 4'b0001;
    predict();
    run_window();
    checks++;
    if (obs_close !== exp_close) begin
      failures++;
      $display("[TB] FAIL boundary_edge: actual=%0d required=%0d", obs_close, exp_close);
    end
    checks++;
    if (obs_ballot !== 4'b0110 || obs_voted !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL boundary_ballot: actual b=%b v=%b required b=0110 v=0110",
               obs_ballot, obs_voted);
    end
    ack_edge();
  endtask

  task automatic test_invalid();
    clear_seq();
    seq_yes[1] = 4'b0001;
    seq_no[1]  = 4'b0001;
    seq_yes[2] = 4'b0010;
    seq_no[4]  = 4'b0010;
    predict();
    run_window();
    checks++;
    if (obs_voted[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL invalid_both: actual voted[0]=%b required 0", obs_voted[0]);
    end
    checks++;
    if (obs_ballot[1] !== !REVOTE || obs_voted !== exp_voted) begin
      failures++;
      $display("[TB] FAIL duplicate_vote: actual ballot[1]=%b v=%b required ballot[1]=%b v=%b",
               obs_ballot[1], obs_voted, !REVOTE, exp_voted);
    end
    ack_edge();
  endtask

  task automatic test_handshake();
    int bad_cycles;
    clear_seq();
    seq_yes[2] = 4'b1001;
    seq_no[5]  = 4'b0100;
    predict();
    run_window();
    bad_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      start = c[0];
      @(posedge clk);
      @(negedge clk);
      if (ballot !== exp_ballot || voted !== exp_voted || ballot_valid !== 1'b1) bad_cycles++;
    end
    start = 1'b0;
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("[TB] FAIL hold_stable: actual %0d unstable cycles (b=%b valid=%b) required 0 (b=%b valid=1)",
               bad_cycles, ballot, ballot_valid, exp_ballot);
    end
    start      = 1'b1;
    ballot_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ballot_ack = 1'b0;
    checks++;
    if (ballot_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_to_idle: actual valid=%b busy=%b required 0/0", ballot_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || voted !== 4'b0000 || ballot !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reopen: actual busy=%b v=%b b=%b required 1/0000/0000", busy, voted, ballot);
    end
    repeat (W) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (ballot_valid !== 1'b1 || ballot !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reopen_timeout: actual valid=%b b=%b required 1/0000", ballot_valid, ballot);
    end
    ack_edge();
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      clear_seq();
      for (int j = 1; j <= W + 3; j++) begin
        seq_yes[j] = 4'($urandom & $urandom & $urandom);
        seq_no[j]  = 4'($urandom & $urandom & $urandom);
      end
      predict();
      run_window();
      checks++;
      if (obs_close !== exp_close || obs_ballot !== exp_ballot || obs_voted !== exp_voted) begin
        failures++;
        $display("[TB] FAIL random_window_%0d: actual close=%0d b=%b v=%b required close=%0d b=%b v=%b",
                 n, obs_close, obs_ballot, obs_voted, exp_close, exp_ballot, exp_voted);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      ack_edge();
      checks++;
      if (ballot_valid !== 1'b0 || ballot !== exp_ballot) begin
        failures++;
        $display("[TB] FAIL random_ack_%0d: actual valid=%b b=%b required 0/%b",
                 n, ballot_valid, ballot, exp_ballot);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    vote_yes   = 4'b0000;
    vote_no    = 4'b0000;
    ballot_ack = 1'b0;
    test_reset();
    test_early_close();
    test_timeout();
    test_boundary();
    test_invalid();
    test_handshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/vote_collector.md
# vote_collector

Ballot-collection stage that feeds the 4-voter classifier. Opens a timed voting window on request, latches at most one yes/no vote per voter, closes the window when all four have voted or the window expires, then holds the 4-bit ballot vector (1 = yes) with a valid/ack handshake until the classifier side consumes it.

## Interface
- WINDOW_CYCLES, default 1000: voting-window length in clock cycles; legal range 2 to 65535.
- CNT_W, default 16: width of the window counter; must hold WINDOW_CYCLES-1.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  open a window; sampled only in IDLE.
- vote_yes  in  4  per-voter yes strobe; bit i = voter i.
- vote_no  in  4  per-voter no strobe.
- ballot_ack  in  1  downstream accepts ballot; sampled only in HOLD.
- ballot  out  4  registered yes mask; drives the classifier's 4-bit input.
- ballot_valid  out  1  ballot is complete and stable.
- voted  out  4  registered mask of voters who have cast a vote in the current window.
- busy  out  1  high in OPEN and HOLD.

## Operation
- Reset values: state IDLE, ballot=4'b0000, ballot_valid=0, voted=4'b0000, busy=0, counter=0.
- FSM has three states: IDLE, OPEN, and HOLD.
- IDLE: on start=1, go to OPEN. Clear ballot, voted, and counter in the same edge.
- OPEN, per voter i, evaluated at each edge:
  - vote_yes[i]=1 and vote_no[i]=0: sets voted[i] and ballot[i].
  - vote_no[i]=1 and vote_yes[i]=0: sets voted[i] and clears ballot[i].
  - Both strobes high: invalid; ignored, no state change for that voter.
  - voted[i] already set: strobes ignored (first vote wins).
- OPEN close condition, evaluated with this edge's votes included: (voted after update)==4'b1111, or counter==WINDOW_CYCLES-1. If true, go to HOLD. Otherwise increment the counter.
- Voters that never vote count as no; their ballot bit stays 0.
- HOLD: ballot_valid=1; ballot and voted frozen; all strobes ignored. On ballot_ack=1, go to IDLE and drop ballot_valid. ballot keeps its value until the next start.
- start outside IDLE is ignored. ballot_ack outside HOLD is ignored.
- Reset asserted in any state: all outputs return to reset values immediately. No partial ballot is ever presented.

## Timing
- start sampled high at edge k: busy=1 from k onward. Votes are accepted at edges k+1 through k+WINDOW_CYCLES.
- Timeout: window closes at edge k+WINDOW_CYCLES; ballot_valid=1 after that edge.
- Early close: ballot_valid rises right after the edge that captured the fourth vote. Latency is 0 cycles beyond that vote's edge.
- ballot_valid drops right after the edge where ballot_ack=1 is sampled. A start can be accepted at the following edge, so there is at least one IDLE cycle between windows.
- A vote strobe on the closing edge is counted. A strobe on the edge after closing is dropped.

## Configuration
- VOTE_REVOTE_EN defined:
  - A voter may recast during OPEN; the last valid strobe wins and voted[i] stays set.
  - Early close on all-voted is disabled; the window always runs the full WINDOW_CYCLES.
- VOTE_REVOTE_EN undefined: first-vote-wins and early close, as described in Operation.

## Test plan
- Reset mid-window: WINDOW_CYCLES=8, start, voter 0 votes yes, assert rst -> ballot=0000, voted=0000, busy=0, ballot_valid=0 asynchronously; FSM in IDLE.
- Early close: start; yes on voters 0,1,2 and no on voter 3 on successive cycles -> ballot_valid rises after the 4th vote's edge with ballot=0111, voted=1111; ack -> valid drops next cycle.
- Timeout: WINDOW_CYCLES=8; start; only voter 2 votes yes -> ballot_valid exactly 8 edges after start, with ballot=0100 and voted=0100.
- Vote on the boundary: with the same setup, voter 1 votes yes on the closing edge -> ballot=0110. A strobe one edge later is ignored.
- Invalid and duplicate strobes:
  - Voter 0 with yes and no together -> ignored; voted[0]=0.
  - Voter 1 votes yes, then no -> ballot[1]=1 when VOTE_REVOTE_EN is undefined, ballot[1]=0 when it is defined.
- Handshake: hold ballot_ack low for 20 cycles in HOLD -> ballot and ballot_valid remain stable. A start during HOLD is ignored. Ack and start on the next edge -> exactly one IDLE cycle, then a new window opens.
